hiss_tx_deser: RTL and testbench
================================

Name: hiss_tx_deser

Overview:
- Digital deserializer directly downstream of the HISS LVDS pad receivers.
- Consumes the single-ended serial I and Q bit streams (hiss_txi, hiss_txq) recovered by the LVDS receivers.
- Frames each stream into parallel DATA_W-bit I/Q sample pairs and presents them to the baseband core with a one-cycle valid strobe.
- Detects framing errors and keeps saturating good-frame and error counters for the register block.

Parameters:
DATA_W, 8, bits per I and per Q sample in one frame.
CNT_W, 8, width of the frame and error counters.

Ports:
hiss_clk  input  1  bit clock; all sampling on rising edge.
hiss_reset  input  1  asynchronous, active-high reset.
hiss_deser_en  input  1  deserializer enable; low forces IDLE.
hiss_txi  input  1  serial I bit from LVDS receiver.
hiss_txq  input  1  serial Q bit from LVDS receiver.
cnt_clr  input  1  synchronous clear of frame_cnt and err_cnt.
rx_i_data  output  DATA_W  last good I sample.
rx_q_data  output  DATA_W  last good Q sample.
rx_valid  output  1  one-cycle strobe, rx_i_data/rx_q_data updated.
rx_frame_err  output  1  one-cycle strobe on stop-bit violation.
busy  output  1  high while in DATA or STOP state.
frame_cnt  output  CNT_W  good frames received, saturating.
err_cnt  output  CNT_W  framing errors, saturating.

Behaviour:
- Reset (async, active-high): state=IDLE. Shift registers, rx_i_data, rx_q_data, frame_cnt and err_cnt are 0. rx_valid, rx_frame_err and busy are 0.
- Frame format, sampled one bit per hiss_clk:
  - Start: txi=1 AND txq=1 in the same cycle.
  - Data: DATA_W cycles, MSB first, I bits on txi and Q bits on txq in parallel.
  - Stop: one cycle, txi=0 AND txq=0 required.
- States:
  - IDLE: if en=1 and txi=1 and txq=1 -> DATA, bit counter=0. Only one line high -> stay in IDLE, no error.
  - DATA: shift txi into the I shifter and txq into the Q shifter each cycle. After the DATA_W-th bit -> STOP.
  - STOP: if txi=0 and txq=0, load output registers from the shifters, pulse rx_valid, increment frame_cnt. Otherwise pulse rx_frame_err, increment err_cnt, and leave the outputs unchanged. Both cases -> IDLE.
- Latency:
  - Start sampled at cycle k; data at k+1..k+DATA_W; stop at k+DATA_W+1.
  - rx_valid/rx_frame_err registered, high during cycle k+DATA_W+2, exactly one cycle.
  - Data outputs change in that same cycle and hold until the next good frame.
- Back-to-back: a new start bit may be sampled in cycle k+DATA_W+2, the first IDLE cycle. No gap cycle is required; a frame rate of one per DATA_W+2 cycles is sustained.
- busy=1 in DATA and STOP, registered with state.
- hiss_deser_en=0 in any state: next state IDLE, partial frame discarded, no strobe, no counter change.
- Counters:
  - Saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
  - cnt_clr does not affect the state machine.
- No data on rx_i/q_data is ever produced from an errored or aborted frame.
- Input bits with X/Z are treated per simulator semantics; the bench drives only 0/1.

Test Plan:
- Single frame, DATA_W=8: start, I=0xA5, Q=0x3C MSB first, stop 00 -> rx_valid one cycle at start+10, rx_i_data=0xA5, rx_q_data=0x3C, frame_cnt=1, err_cnt=0.
- Bad stop: start, I=0xFF, Q=0x00, stop txi=1 txq=0 -> rx_frame_err one cycle at start+10, rx_valid stays 0, outputs keep previous 0xA5/0x3C, err_cnt=1.
- Back-to-back: three frames (0x01/0x80, 0x02/0x40, 0x03/0x20), each start placed immediately after the previous stop -> rx_valid at cycles 10, 20, 30 with matching data, frame_cnt=3.
- Abort mid-frame: drop hiss_deser_en after 4 data bits for one cycle, then send a full frame 0x5A/0xC3 -> the first frame produces no strobe; the second gives rx_valid with 0x5A/0xC3; counters increment only for the second.
- Saturation and clear, CNT_W=8: send 260 good frames -> frame_cnt=255. Assert cnt_clr in the same cycle as a rx_valid -> frame_cnt=0 the next cycle.
- Reset mid-frame: assert hiss_reset asynchronously during data bit 5 -> all outputs 0 immediately and busy=0. A full frame after release is received correctly.
- One-line start: txi=1, txq=0 for 3 cycles in IDLE -> no state change, busy=0, no strobes.

Source files
------------

// File: rtl/hiss_tx_deser_if.sv
// HISS deserializer bus interface.
// Carries the serial inputs recovered by the LVDS pad receivers (enable,
// I/Q bits, counter clear) toward the deserializer, and the framed parallel
// samples, strobes, busy flag and counters back toward the baseband/register side.
//   master : drives hiss_deser_en, hiss_txi, hiss_txq, cnt_clr; observes outputs
//   slave  : the deserializer itself
interface hiss_tx_deser_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              hiss_deser_en;
    logic              hiss_txi;
    logic              hiss_txq;
    logic              cnt_clr;
    logic [DATA_W-1:0] rx_i_data;
    logic [DATA_W-1:0] rx_q_data;
    logic              rx_valid;
    logic              rx_frame_err;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output hiss_deser_en, hiss_txi, hiss_txq, cnt_clr,
        input  rx_i_data, rx_q_data, rx_valid, rx_frame_err, busy, frame_cnt, err_cnt
    );

    modport slave (
        input  hiss_deser_en, hiss_txi, hiss_txq, cnt_clr,
        output rx_i_data, rx_q_data, rx_valid, rx_frame_err, busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/hiss_tx_deser.sv
// HISS transmit-path deserializer.
// Frames the serial I/Q bit streams from the LVDS receivers into parallel
// DATA_W-bit sample pairs. Frame: start (I=1,Q=1), DATA_W data bits MSB first,
// stop (I=0,Q=0). Good frames update rx_i_data/rx_q_data with a one-cycle
// rx_valid; a bad stop gives a one-cycle rx_frame_err and leaves data untouched.
// Saturating frame_cnt/err_cnt with synchronous clear.
//   hiss_clk   : bit clock, rising edge
//   hiss_reset : asynchronous, active-high reset
//   bus        : hiss_tx_deser_if slave modport (serial in, parallel/status out)
//
//   state | meaning
//   IDLE  | waiting for start (both lines high while enabled)
//   DATA  | shifting DATA_W bits into the I/Q shifters
//   STOP  | checking the stop bit, committing or rejecting the frame
module hiss_tx_deser #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic               hiss_clk,
    input  logic               hiss_reset,
    hiss_tx_deser_if.slave     bus
);
    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   i_shift_q, i_shift_d;
    logic [DATA_W-1:0]   q_shift_q, q_shift_d;
    logic [DATA_W-1:0]   rx_i_q, rx_i_d;
    logic [DATA_W-1:0]   rx_q_q, rx_q_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_err_q, rx_err_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        i_shift_d   = i_shift_q;
        q_shift_d   = q_shift_q;
        rx_i_d      = rx_i_q;
        rx_q_d      = rx_q_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (!bus.hiss_deser_en) begin
            // Disabling drops any partial frame silently.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.hiss_txi && bus.hiss_txq) begin
                        state_d   = DATA;
                        bit_cnt_d = BCNT_W'(DATA_W - 1);
                    end
                end
                DATA: begin
                    i_shift_d = {i_shift_q[DATA_W-2:0], bus.hiss_txi};
                    q_shift_d = {q_shift_q[DATA_W-2:0], bus.hiss_txq};
                    if (bit_cnt_q == '0) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (!bus.hiss_txi && !bus.hiss_txq) begin
                        rx_i_d     = i_shift_q;
                        rx_q_d     = q_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (rx_valid_d && (frame_cnt_q != CNT_MAX)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (rx_err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        // Clear wins over a same-cycle increment.
        if (bus.cnt_clr) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end

        busy_d = (state_d == DATA) || (state_d == STOP);
    end

    always_ff @(posedge hiss_clk or posedge hiss_reset) begin
        if (hiss_reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            i_shift_q   <= '0;
            q_shift_q   <= '0;
            rx_i_q      <= '0;
            rx_q_q      <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            i_shift_q   <= i_shift_d;
            q_shift_q   <= q_shift_d;
            rx_i_q      <= rx_i_d;
            rx_q_q      <= rx_q_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.rx_i_data    = rx_i_q;
    assign bus.rx_q_data    = rx_q_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_frame_err = rx_err_q;
    assign bus.busy         = busy_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_hiss_tx_deser.sv
module tb_hiss_tx_deser;
    logic hiss_clk = 1'b0;
    logic hiss_reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        bit         err;
        logic [7:0] i;
        logic [7:0] q;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_i = 8'h00;
    logic [7:0] model_q = 8'h00;
    logic [7:0] exp_frame = 8'h00;
    logic [7:0] exp_err = 8'h00;

    hiss_tx_deser_if #(.DATA_W(8), .CNT_W(8)) bus ();

    hiss_tx_deser #(.DATA_W(8), .CNT_W(8)) dut (
        .hiss_clk   (hiss_clk),
        .hiss_reset (hiss_reset),
        .bus        (bus)
    );

    always #5 hiss_clk = ~hiss_clk;
    always @(posedge hiss_clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expectation exactly.
    always @(negedge hiss_clk) begin
        if (!hiss_reset && (bus.rx_valid || bus.rx_frame_err)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got valid=%0b err=%0b at cyc %0d, required no strobe",
                         bus.rx_valid, bus.rx_frame_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rx_valid !== !e.err || bus.rx_frame_err !== e.err || cyc != e.at ||
                    bus.rx_i_data !== e.i || bus.rx_q_data !== e.q) begin
                    n_fail++;
                    $display("FAIL strobe: got valid=%0b err=%0b cyc=%0d i=%h q=%h, required valid=%0b err=%0b cyc=%0d i=%h q=%h",
                             bus.rx_valid, bus.rx_frame_err, cyc, bus.rx_i_data, bus.rx_q_data,
                             !e.err, e.err, e.at, e.i, e.q);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge hiss_clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.hiss_txi = 1'b0;
        bus.hiss_txq = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] i, input logic [7:0] q,
                              input logic si, input logic sq, input logic clr);
        exp_t e;
        bus.hiss_txi = 1'b1;
        bus.hiss_txq = 1'b1;
        tick();
        e.err = si | sq;
        e.at  = cyc + 9;
        if (e.err) begin
            e.i = model_i;
            e.q = model_q;
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        end else begin
            e.i = i;
            e.q = q;
            model_i = i;
            model_q = q;
            if (exp_frame != 8'hFF) exp_frame = exp_frame + 8'd1;
        end
        if (clr) begin
            exp_frame = 8'h00;
            exp_err   = 8'h00;
        end
        sb.push_back(e);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %0b, required 1", bus.busy);
        end
        for (int b = 7; b >= 0; b--) begin
            bus.hiss_txi = i[b];
            bus.hiss_txq = q[b];
            tick();
        end
        bus.hiss_txi = si;
        bus.hiss_txq = sq;
        bus.cnt_clr  = clr;
        tick();
        bus.cnt_clr  = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_stop: got %0b, required 0", bus.busy);
        end
    endtask

    task automatic check_state(input string name);
        idle(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d strobes outstanding, required 0", name, sb.size());
            sb.delete();
        end
        n_checks++;
        if (bus.frame_cnt !== exp_frame || bus.err_cnt !== exp_err) begin
            n_fail++;
            $display("FAIL %s_counters: got frame=%0d err=%0d, required frame=%0d err=%0d",
                     name, bus.frame_cnt, bus.err_cnt, exp_frame, exp_err);
        end
        n_checks++;
        if (bus.rx_i_data !== model_i || bus.rx_q_data !== model_q) begin
            n_fail++;
            $display("FAIL %s_data: got i=%h q=%h, required i=%h q=%h",
                     name, bus.rx_i_data, bus.rx_q_data, model_i, model_q);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (bus.rx_i_data !== 8'h00 || bus.rx_q_data !== 8'h00 || bus.rx_valid !== 1'b0 ||
            bus.rx_frame_err !== 1'b0 || bus.busy !== 1'b0 || bus.frame_cnt !== 8'h00 ||
            bus.err_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: got i=%h q=%h v=%0b e=%0b busy=%0b fc=%0d ec=%0d, required all 0",
                     name, bus.rx_i_data, bus.rx_q_data, bus.rx_valid, bus.rx_frame_err,
                     bus.busy, bus.frame_cnt, bus.err_cnt);
        end
    endtask

    task automatic test_reset();
        bus.hiss_deser_en = 1'b1;
        bus.hiss_txi      = 1'b0;
        bus.hiss_txq      = 1'b0;
        bus.cnt_clr       = 1'b0;
        hiss_reset        = 1'b1;
        repeat (3) @(posedge hiss_clk);
        #2;
        check_all_zero("reset_values");
        @(negedge hiss_clk);
        hiss_reset = 1'b0;
        tick();
        check_all_zero("after_release");
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
        check_state("single");
    endtask

    task automatic test_bad_stop();
        send_frame(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        check_state("bad_stop");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h01, 8'h80, 1'b0, 1'b0, 1'b0);
        send_frame(8'h02, 8'h40, 1'b0, 1'b0, 1'b0);
        send_frame(8'h03, 8'h20, 1'b0, 1'b0, 1'b0);
        check_state("back_to_back");
    endtask

    task automatic test_abort();
        bus.hiss_txi = 1'b1;
        bus.hiss_txq = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            bus.hiss_txi = b[0];
            bus.hiss_txq = ~b[0];
            tick();
        end
        bus.hiss_deser_en = 1'b0;
        bus.hiss_txi      = 1'b1;
        bus.hiss_txq      = 1'b1;
        tick();
        bus.hiss_deser_en = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %0b, required 0", bus.busy);
        end
        send_frame(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0);
        check_state("abort");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            send_frame(n[7:0], ~n[7:0], 1'b0, 1'b0, 1'b0);
        end
        check_state("saturate");
        n_checks++;
        if (bus.frame_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturate_value: got %0d, required 255", bus.frame_cnt);
        end
        send_frame(8'h77, 8'h88, 1'b1, 1'b1, 1'b0);
        send_frame(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        check_state("clear_priority");
    endtask

    task automatic test_reset_mid();
        bus.hiss_txi = 1'b1;
        bus.hiss_txq = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            bus.hiss_txi = 1'b1;
            bus.hiss_txq = 1'b0;
            tick();
        end
        #2;
        hiss_reset = 1'b1;
        #1;
        check_all_zero("reset_mid_async");
        #2;
        hiss_reset = 1'b0;
        model_i   = 8'h00;
        model_q   = 8'h00;
        exp_frame = 8'h00;
        exp_err   = 8'h00;
        idle(2);
        send_frame(8'h96, 8'h69, 1'b0, 1'b0, 1'b0);
        check_state("reset_mid");
    endtask

    task automatic test_one_line();
        bus.hiss_txi = 1'b1;
        bus.hiss_txq = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL one_line_busy: got %0b, required 0", bus.busy);
            end
        end
        check_state("one_line");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bad_stop();
        test_back_to_back();
        test_abort();
        test_saturation();
        test_reset_mid();
        test_one_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
